// File: rtl/exp4_trena_agendador.sv
// Measurement scheduler for the trena control unit.
// It issues one-cycle mensurar pulses in one of two modes:
//   - continuous, with a hold-off interval between pulses;
//   - single shot, one pulse per disparo rising edge.
// It watches pronto with a timeout, pulses zera_trena to recover the trena
// after a timeout, and counts completed and failed measurements.
//
// Ports:
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   ligar             level enable; 0 returns to INATIVO from any state
//   modo              1 = continuous, 0 = single shot on disparo rising edge
//   disparo           single-shot trigger level (edge detected internally)
//   limpa             synchronous clear of the counters and erro
//   pronto            trena done indication, sampled only while waiting
//   mensurar          one-cycle start pulse (DISPARA state)
//   zera_trena        one-cycle recovery pulse (FALHA state)
//   medindo           high in DISPARA or AGUARDA
//   erro              sticky timeout flag
//   contagem_medidas  completed measurements, wraps
//   contagem_erros    timeouts, saturates at 15
//   db_estado         state code; 4'hF for an illegal state register
module exp4_trena_agendador #(
  parameter int unsigned INTERVALO = 50_000_000,
  parameter int unsigned TIMEOUT   = 25_000_000,
  parameter int unsigned W_CONT    = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       modo,
  input  logic       disparo,
  input  logic       limpa,
  input  logic       pronto,
  output logic       mensurar,
  output logic       zera_trena,
  output logic       medindo,
  output logic       erro,
  output logic [7:0] contagem_medidas,
  output logic [3:0] contagem_erros,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    E_INATIVO   = 3'b000,
    E_OCIOSO    = 3'b001,
    E_DISPARA   = 3'b010,
    E_AGUARDA   = 3'b011,
    E_INTERVALO = 3'b100,
    E_FALHA     = 3'b101
  } estado_t;

  estado_t           estado;
  estado_t           estado_prox;
  logic [W_CONT-1:0] cont;
  logic              cont_zera;
  logic              cont_inc;
  logic              conta_medida;
  logic              conta_erro;
  logic              disparo_ant;
  logic              disparo_sobe;

  assign disparo_sobe = disparo & ~disparo_ant;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= E_INATIVO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next state and counter/statistics control
  always_comb begin
    estado_prox  = estado;
    cont_zera    = 1'b0;
    cont_inc     = 1'b0;
    conta_medida = 1'b0;
    conta_erro   = 1'b0;
    if (!ligar) begin
      estado_prox = E_INATIVO;
    end else begin
      case (estado)
        E_INATIVO: estado_prox = E_OCIOSO;
        E_OCIOSO: begin
          if (modo || disparo_sobe) begin
            estado_prox = E_DISPARA;
          end
        end
        E_DISPARA: begin
          estado_prox = E_AGUARDA;
          cont_zera   = 1'b1;
        end
        E_AGUARDA: begin
          // pronto wins even on the last allowed cycle
          if (pronto) begin
            estado_prox  = E_INTERVALO;
            conta_medida = 1'b1;
            cont_zera    = 1'b1;
          end else if (cont == W_CONT'(TIMEOUT - 1)) begin
            estado_prox = E_FALHA;
          end else begin
            cont_inc = 1'b1;
          end
        end
        E_INTERVALO: begin
          if (cont == W_CONT'(INTERVALO - 1)) begin
            estado_prox = E_OCIOSO;
          end else begin
            cont_inc = 1'b1;
          end
        end
        E_FALHA: begin
          estado_prox = E_INTERVALO;
          conta_erro  = 1'b1;
          cont_zera   = 1'b1;
        end
        default: estado_prox = E_INATIVO;
      endcase
    end
  end

  // Shared cycle counter for the timeout and the hold-off interval
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont <= '0;
    end else if (cont_zera) begin
      cont <= '0;
    end else if (cont_inc) begin
      cont <= cont + W_CONT'(1);
    end
  end

  // Edge detector and statistics; limpa beats same-cycle increments
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disparo_ant      <= 1'b0;
      contagem_medidas <= 8'd0;
      contagem_erros   <= 4'd0;
      erro             <= 1'b0;
    end else begin
      disparo_ant <= disparo;
      if (limpa) begin
        contagem_medidas <= 8'd0;
        contagem_erros   <= 4'd0;
        erro             <= 1'b0;
      end else begin
        if (conta_medida) begin
          contagem_medidas <= contagem_medidas + 8'd1;
        end
        if (conta_erro) begin
          erro <= 1'b1;
          if (contagem_erros != 4'hF) begin
            contagem_erros <= contagem_erros + 4'd1;
          end
        end
      end
    end
  end

  // Moore decodes of the registered state
  assign mensurar   = (estado == E_DISPARA);
  assign zera_trena = (estado == E_FALHA);
  assign medindo    = (estado == E_DISPARA) || (estado == E_AGUARDA);

  always_comb begin
    case (estado)
      E_INATIVO, E_OCIOSO, E_DISPARA,
      E_AGUARDA, E_INTERVALO, E_FALHA: db_estado = {1'b0, estado};
      default:                         db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_exp4_trena_agendador.sv
// Self-checking bench for exp4_trena_agendador with INTERVALO=8, TIMEOUT=16.
// A phase-level model predicts every output each cycle; directed scenarios
// add literal checks on pulse spacing and counter values.
`timescale 1ns/1ps
module tb_exp4_trena_agendador;

  localparam int INTERVALO = 8;
  localparam int TIMEOUT   = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ligar = 1'b0;
  logic       modo = 1'b0;
  logic       disparo = 1'b0;
  logic       limpa = 1'b0;
  logic       pronto_man = 1'b0;
  logic       pronto_auto = 1'b0;
  logic       pronto;
  logic       mensurar, zera_trena, medindo, erro;
  logic [7:0] contagem_medidas;
  logic [3:0] contagem_erros;
  logic [3:0] db_estado;

  assign pronto = pronto_man | pronto_auto;

  exp4_trena_agendador #(
    .INTERVALO(INTERVALO),
    .TIMEOUT  (TIMEOUT),
    .W_CONT   (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ligar           (ligar),
    .modo            (modo),
    .disparo         (disparo),
    .limpa           (limpa),
    .pronto          (pronto),
    .mensurar        (mensurar),
    .zera_trena      (zera_trena),
    .medindo         (medindo),
    .erro            (erro),
    .contagem_medidas(contagem_medidas),
    .contagem_erros  (contagem_erros),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_OFF = 0, PH_IDLE = 1, PH_FIRE = 2, PH_WAIT = 3, PH_HOLD = 4, PH_FAIL = 5;

  typedef struct packed {
    int ph;
    int waited;     // cycles already spent waiting for pronto
    int hold_left;  // hold-off cycles still to go
    int meds;
    int errs;
    bit err;
    bit prev;
  } model_t;

  model_t m = '0;

  function automatic model_t model_step(model_t s, logic lg, logic md, logic dp, logic lp, logic pr);
    model_t n = s;
    n.prev = dp;
    if (lp) begin
      n.meds = 0;
      n.errs = 0;
      n.err  = 1'b0;
    end
    if (!lg) begin
      n.ph = PH_OFF;
    end else begin
      case (s.ph)
        PH_OFF:  n.ph = PH_IDLE;
        PH_IDLE: if (md || (dp && !s.prev)) n.ph = PH_FIRE;
        PH_FIRE: begin
          n.ph     = PH_WAIT;
          n.waited = 0;
        end
        PH_WAIT: begin
          n.waited = s.waited + 1;
          if (pr) begin
            if (!lp) n.meds = (s.meds + 1) % 256;
            n.ph        = PH_HOLD;
            n.hold_left = INTERVALO;
          end else if (n.waited == TIMEOUT) begin
            n.ph = PH_FAIL;
          end
        end
        PH_HOLD: begin
          n.hold_left = s.hold_left - 1;
          if (n.hold_left == 0) n.ph = PH_IDLE;
        end
        PH_FAIL: begin
          if (!lp) begin
            n.err  = 1'b1;
            n.errs = (s.errs < 15) ? s.errs + 1 : 15;
          end
          n.ph        = PH_HOLD;
          n.hold_left = INTERVALO;
        end
        default: n.ph = PH_OFF;
      endcase
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m, ligar, modo, disparo, limpa, pronto);
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    check("mensurar", mensurar, m.ph == PH_FIRE);
    check("zera_trena", zera_trena, m.ph == PH_FAIL);
    check("medindo", medindo, (m.ph == PH_FIRE) || (m.ph == PH_WAIT));
    check("erro", erro, m.err);
    check("contagem_medidas", contagem_medidas, m.meds);
    check("contagem_erros", contagem_erros, m.errs);
    check("db_estado", db_estado, m.ph);
  end

  // ---------------- monitors and pronto responder ----------------
  int pulses[$];
  int zeras[$];
  int auto_delay = 0;
  int pcnt = 0;
  int n_prontos = 0;

  always @(negedge clock) begin
    if (mensurar === 1'b1) pulses.push_back(cyc);
    if (zera_trena === 1'b1) zeras.push_back(cyc);
    pronto_auto <= (pcnt == 1);
    if (pcnt == 1) n_prontos <= n_prontos + 1;
    if (mensurar === 1'b1 && auto_delay > 0) pcnt <= auto_delay;
    else if (pcnt > 0)                       pcnt <= pcnt - 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  function automatic int count_of(input int sel);
    case (sel)
      0:       return pulses.size();
      1:       return zeras.size();
      default: return n_prontos;
    endcase
  endfunction

  // sel 0: mensurar pulses, 1: zera pulses, 2: prontos, 3: db_estado==target
  task automatic wait_for(input int sel, input int target, input int budget, input string what);
    int b = 0;
    while (b < budget && ((sel == 3) ? (int'(db_estado) != target) : (count_of(sel) < target))) begin
      tick(1);
      b++;
    end
    if ((sel == 3) ? (int'(db_estado) != target) : (count_of(sel) < target)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait expired after %0d cycles (cycle %0d)", what, budget, cyc);
    end
  endtask

  task automatic pulse_limpa();
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base, zb, c0, pb;

    tick(3);
    check("reset db_estado", db_estado, 0);
    check("reset contagem_medidas", contagem_medidas, 0);
    check("reset mensurar", mensurar, 0);
    reset = 1'b0;
    tick(2);
    check("idle without ligar", db_estado, 0);

    // Continuous mode, pronto 5 cycles after each mensurar
    auto_delay = 5;
    base = pulses.size();
    c0 = cyc;
    ligar = 1'b1;
    modo = 1'b1;
    wait_for(0, base + 4, 100, "continuous pulses");
    if (pulses.size() >= base + 4) begin
      check("first mensurar latency", pulses[base] - c0, 2);
      check("period 1-2", pulses[base+1] - pulses[base], 15);
      check("period 3-4", pulses[base+3] - pulses[base+2], 15);
    end
    check("continuous count", contagem_medidas, 3);
    ligar = 1'b0;
    tick(2);
    check("ligar drop state", db_estado, 0);
    check("ligar drop keeps count", contagem_medidas, 3);
    pulse_limpa();
    check("limpa clears count", contagem_medidas, 0);
    tick(20);

    // Single shot
    modo = 1'b0;
    ligar = 1'b1;
    base = pulses.size();
    tick(100);
    check("no disparo no pulse", pulses.size() - base, 0);
    disparo = 1'b1;
    tick(40);
    disparo = 1'b0;
    tick(5);
    check("one pulse per disparo edge", pulses.size() - base, 1);
    check("single shot count", contagem_medidas, 1);
    ligar = 1'b0;
    tick(20);
    pulse_limpa();

    // Timeouts
    auto_delay = 0;
    zb = zeras.size();
    base = pulses.size();
    modo = 1'b1;
    ligar = 1'b1;
    wait_for(1, zb + 1, 100, "first timeout");
    if (zeras.size() > zb && pulses.size() > base)
      check("mensurar to zera", zeras[zb] - pulses[base], 17);
    tick(1);
    check("erro after timeout", erro, 1);
    check("erros after timeout", contagem_erros, 1);
    wait_for(0, base + 2, 50, "pulse after timeout");
    if (zeras.size() > zb && pulses.size() > base + 1)
      check("zera to next mensurar", pulses[base+1] - zeras[zb], 10);
    wait_for(1, zb + 20, 700, "20 timeouts");
    tick(1);
    check("erros saturate", contagem_erros, 15);
    check("erro sticky", erro, 1);
    check("no successes on timeout", contagem_medidas, 0);
    ligar = 1'b0;
    tick(20);
    pulse_limpa();
    check("limpa clears erro", erro, 0);

    // pronto on the last allowed waiting cycle
    auto_delay = 16;
    zb = zeras.size();
    base = pulses.size();
    ligar = 1'b1;
    wait_for(0, base + 3, 120, "late pronto pulses");
    check("late pronto no zera", zeras.size() - zb, 0);
    check("late pronto counts", contagem_medidas, 2);
    check("late pronto no erro", erro, 0);
    ligar = 1'b0;
    tick(25);

    // ligar dropped while waiting
    auto_delay = 0;
    zb = zeras.size();
    base = pulses.size();
    ligar = 1'b1;
    wait_for(0, base + 1, 10, "pulse before drop");
    tick(3);
    check("waiting state", db_estado, 3);
    ligar = 1'b0;
    tick(1);
    check("drop to INATIVO", db_estado, 0);
    check("drop medindo", medindo, 0);
    check("drop keeps count", contagem_medidas, 2);
    tick(20);
    check("drop no zera", zeras.size() - zb, 0);

    // Asynchronous reset during the hold-off interval
    auto_delay = 5;
    ligar = 1'b1;
    wait_for(3, 4, 60, "reach INTERVALO");
    check("count before reset", contagem_medidas, 3);
    #2;
    reset = 1'b1;
    #1;
    check("async reset state", db_estado, 0);
    check("async reset count", contagem_medidas, 0);
    ligar = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(20);

    // Wrap of contagem_medidas after 256 successes
    auto_delay = 5;
    pb = n_prontos;
    ligar = 1'b1;
    wait_for(2, pb + 256, 256 * 15 + 60, "256 prontos");
    tick(1);
    check("count wraps", contagem_medidas, 0);
    wait_for(2, pb + 257, 30, "pronto 257");
    tick(1);
    check("count after wrap", contagem_medidas, 1);
    wait_for(2, pb + 258, 30, "pronto 258");
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    check("limpa beats pronto", contagem_medidas, 0);
    check("limpa erros", contagem_erros, 0);
    check("success still taken", db_estado, 4);
    ligar = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
